uart_tx_scheduler: RTL and testbench

Shares one `mUart` transmitter between `NUM_REQ` byte producers. It arbitrates round-robin, holds the grant across multi-byte packets, and drives the UART's `dataIn`/`txReset` pair. It watches `txComplete` to sequence one byte at a time. It sits between the application logic (counters, status reporters, debug taps) and the single `mUart` instance in `top`.

---
 rtl/uart_pkg.sv | 10 +
 rtl/rr_pick.sv | 21 ++
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART scheduler types, baud constants and timeout helper
package uart_pkg;
  typedef enum logic [1:0] {ARB, START, SEND, HOLD} tx_sched_state_e;
  localparam int UART_CLK_SPEED = 27000000;
  localparam int UART_BAUD_RATE = 115200;
  localparam int CLOCK_DELAY = UART_CLK_SPEED / UART_BAUD_RATE;
  function automatic int start_timeout_cycles(input int clk_speed, input int baud);
    return 2 * (clk_speed / baud);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        valid = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-locked sharing of one mUart transmitter
module uart_tx_scheduler import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int START_TIMEOUT = 512,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 grant_active,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_complete,
  output logic                 start_timeout
);
  localparam int SW = $clog2(START_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  tx_sched_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx, next_id;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic [LW-1:0] idle_q, idle_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic grant_active_q, grant_active_d, last_q, last_d, start_timeout_q, start_timeout_d, pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );

  assign next_id = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  assign grant_id = grant_id_q;
  assign grant_active = grant_active_q;
  assign tx_data = tx_data_q;
  assign tx_start = state_q == START;
  assign start_timeout = start_timeout_q;

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d = tx_data_q;
    last_d = last_q;
    start_cnt_d = start_cnt_q;
    idle_d = idle_q;
    start_timeout_d = start_timeout_q;
    req_ready = '0;
    case (state_q)
      ARB: if (tx_complete && pick_valid) begin
        req_ready = NUM_REQ'(1) << pick_idx;
        tx_data_d = req_data[8*int'(pick_idx) +: 8];
        grant_id_d = pick_idx;
        grant_active_d = 1'b1;
        last_d = req_last[pick_idx];
        start_cnt_d = '0;
        state_d = START;
      end
      // tx_start stays high as a level until the UART acknowledges by dropping tx_complete
      START: if (!tx_complete) begin
        start_cnt_d = '0;
        state_d = SEND;
      end else if (start_cnt_q == SW'(START_TIMEOUT)) begin
        start_timeout_d = 1'b1;
      end else begin
        start_cnt_d = start_cnt_q + 1'b1;
      end
      SEND: if (tx_complete) begin
        idle_d = '0;
        state_d = last_q ? ARB : HOLD;
        rr_ptr_d = last_q ? next_id : rr_ptr_q;
        grant_active_d = !last_q;
      end
      HOLD: if (req_valid[grant_id_q]) begin
        req_ready = NUM_REQ'(1) << grant_id_q;
        tx_data_d = req_data[8*int'(grant_id_q) +: 8];
        last_d = req_last[grant_id_q];
        start_cnt_d = '0;
        idle_d = '0;
        state_d = START;
      end else if (idle_q == LW'(LOCK_TIMEOUT - 1)) begin
        idle_d = '0;
        rr_ptr_d = next_id;
        grant_active_d = 1'b0;
        state_d = ARB;
      end else begin
        idle_d = idle_q + 1'b1;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      grant_active_q <= 1'b0;
      tx_data_q <= '0;
      last_q <= 1'b0;
      start_cnt_q <= '0;
      idle_q <= '0;
      start_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q <= tx_data_d;
      last_q <= last_d;
      start_cnt_q <= start_cnt_d;
      idle_q <= idle_d;
      start_timeout_q <= start_timeout_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks against a behavioural mUart and queued requesters
module tb_uart_tx_scheduler;
  localparam int NUM = 4;
  localparam int BYTE_CYC = 2340;
  localparam int LIM = 40000;

  logic clock = 1'b0;
  logic reset;
  logic [NUM-1:0] req_valid, req_last, req_ready, xfer;
  logic [NUM*8-1:0] req_data;
  logic [1:0] grant_id;
  logic grant_active, tx_start, tx_complete, start_timeout;
  logic [7:0] tx_data;
  bit hold_tc = 1'b0;
  int done_cnt = 0;
  int n_cmp = 0, n_err = 0;
  logic [7:0] qd [NUM][$];
  bit ql [NUM][$];
  int log_id[$], log_data[$], log_done[$];

  uart_tx_scheduler #(.NUM_REQ(NUM), .START_TIMEOUT(512), .LOCK_TIMEOUT(100)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .grant_active(grant_active),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_complete(tx_complete),
    .start_timeout(start_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    qd[i].push_back(d);
    ql[i].push_back(l);
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < NUM; i++) if (qd[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_tc(input logic v, input string tag);
    int n = 0;
    while (tx_complete !== v && n < LIM) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_in_time"}, n < LIM, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(q_empty() && !grant_active && tx_complete) && n < LIM) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle_in_time"}, n < LIM, 1);
  endtask

  // mUart model: falls after a short random delay, completes a byte BYTE_CYC later
  initial begin
    tx_complete = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (tx_start && tx_complete && !hold_tc) begin
        repeat ($urandom_range(1, 233)) @(posedge clock);
        #1 tx_complete = 1'b0;
        repeat (BYTE_CYC) @(posedge clock);
        #1 tx_complete = 1'b1;
        done_cnt++;
      end
    end
  end

  // requesters: present queue heads, log and pop each handshake
  initial begin
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clock);
      xfer = req_valid & req_ready;
      for (int i = 0; i < NUM; i++) if (xfer[i]) begin
        log_id.push_back(i);
        log_data.push_back(int'(req_data[8*i +: 8]));
        log_done.push_back(done_cnt);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM; i++) begin
        if (xfer[i]) begin
          void'(qd[i].pop_front());
          void'(ql[i].pop_front());
        end
        req_valid[i] = qd[i].size() != 0;
        req_data[8*i +: 8] = req_valid[i] ? qd[i][0] : 8'h00;
        req_last[i] = req_valid[i] ? ql[i][0] : 1'b0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, base_done, n;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_timeout", start_timeout, 0);
    chk("rst_rr_ptr", dut.rr_ptr_q, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    push(2, 8'h41, 1'b1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_valid[2] && n < LIM);
    chk("single_ready", req_ready, 4'b0100);
    @(negedge clock);
    chk("single_tx_data", tx_data, 8'h41);
    chk("single_tx_start", tx_start, 1);
    chk("single_grant_id", grant_id, 2);
    chk("single_active", grant_active, 1);
    wait_tc(1'b0, "single_fall");
    @(negedge clock);
    chk("single_send_start", tx_start, 0);
    chk("single_send_ready", req_ready, 0);
    wait_idle("single");
    chk("single_rr_ptr", dut.rr_ptr_q, 3);
    chk("single_done_active", grant_active, 0);

    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("rr_ptr_after_reset", dut.rr_ptr_q, 0);
    base = log_id.size();
    base_done = done_cnt;
    for (int i = 0; i < NUM; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    push(0, 8'hA4, 1'b1);
    wait_idle("rr");
    chk("rr_count", log_id.size() - base, 5);
    for (int k = 0; k < 5 && base + k < log_id.size(); k++) begin
      chk($sformatf("rr_id_%0d", k), log_id[base+k], k % NUM);
      chk($sformatf("rr_data_%0d", k), log_data[base+k], 32'hA0 + k);
      chk($sformatf("rr_after_done_%0d", k), log_done[base+k], base_done + k);
    end

    base = log_id.size();
    push(1, "a", 1'b0);
    push(1, "b", 1'b0);
    push(1, "c", 1'b1);
    push(0, 8'h30, 1'b1);
    n = 0;
    while (log_id.size() < base + 2 && n < LIM) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("lock_grant_id_mid", grant_id, 1);
    wait_idle("lock");
    chk("lock_count", log_id.size() - base, 4);
    for (int k = 0; k < 4 && base + k < log_id.size(); k++) begin
      chk($sformatf("lock_id_%0d", k), log_id[base+k], k < 3 ? 1 : 0);
      chk($sformatf("lock_data_%0d", k), log_data[base+k], k < 3 ? 32'h61 + k : 32'h30);
    end

    push(3, 8'h55, 1'b0);
    @(negedge clock);
    wait_tc(1'b0, "lto_fall");
    wait_tc(1'b1, "lto_rise");
    repeat (100) @(negedge clock);
    chk("lto_still_locked", grant_active, 1);
    @(negedge clock);
    chk("lto_released", grant_active, 0);
    chk("lto_rr_ptr", dut.rr_ptr_q, 0);

    hold_tc = 1'b1;
    base = log_id.size();
    push(0, 8'h77, 1'b1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!tx_start && n < LIM);
    repeat (500) @(negedge clock);
    chk("sto_not_yet", start_timeout, 0);
    repeat (20) @(negedge clock);
    chk("sto_flag", start_timeout, 1);
    chk("sto_tx_start", tx_start, 1);
    hold_tc = 1'b0;
    wait_tc(1'b0, "sto_fall");
    wait_idle("sto");
    chk("sto_data", log_data.size() > base ? log_data[base] : -1, 32'h77);
    chk("sto_sticky", start_timeout, 1);

    push(1, 8'h99, 1'b1);
    @(negedge clock);
    wait_tc(1'b0, "rmb_fall");
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    base_done = done_cnt;
    chk("rmb_tx_start", tx_start, 0);
    chk("rmb_active", grant_active, 0);
    chk("rmb_grant_id", grant_id, 0);
    chk("rmb_tx_data", tx_data, 0);
    chk("rmb_timeout", start_timeout, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    base = log_id.size();
    push(2, 8'h12, 1'b1);
    repeat (5) @(negedge clock);
    chk("rmb_no_grant_ready", req_ready, 0);
    chk("rmb_no_grant_log", log_id.size(), base);
    n = 0;
    while (log_id.size() == base && n < LIM) begin
      @(negedge clock);
      n++;
    end
    chk("rmb_grant_in_time", n < LIM, 1);
    chk("rmb_id", log_id.size() > base ? log_id[base] : -1, 2);
    chk("rmb_data", log_data.size() > base ? log_data[base] : -1, 32'h12);
    chk("rmb_after_done", log_done.size() > base ? log_done[base] : -1, base_done + 1);
    wait_idle("rmb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
